// File: rtl/dmem_responder_if.sv
// Processor data-port bundle between a load/store requester and the data-memory responder.
// Valid/ready: the master holds mem_read/mem_write plus address/data until it samples mem_ready=1; mem_err and data_out are meaningful only in that mem_ready cycle.
interface dmem_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;
  logic        mem_ready;
  logic        mem_err;
  logic        busy;

  modport master (
    output data_addr, data_in, mem_read, mem_write,
    input  data_out, mem_ready, mem_err, busy
  );

  modport slave (
    input  data_addr, data_in, mem_read, mem_write,
    output data_out, mem_ready, mem_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Stallable word-addressed data memory: one access at a time, WAIT_CYCLES wait states,
// single-cycle mem_ready/mem_err response strobe.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic [1:0]         dbg_state
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int IW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic          err_q;
  logic [31:0]   data_out_q;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          req_illegal;
  logic          latch_en;
  logic          enter_resp;
  logic [IW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic          cur_write;
  logic          cur_err;
  logic          commit_we;

  logic          busy_c;
  logic          ready_c;
  logic          err_c;

  assign req         = bus.mem_read | bus.mem_write;
  assign req_illegal = (bus.mem_read & bus.mem_write)
                     | (bus.data_addr[1:0] != 2'b00)
                     | ({2'b00, bus.data_addr[31:2]} >= 32'(DEPTH));

  // In IDLE the access resolves on the accepting edge itself (WAIT_CYCLES=0 or error),
  // so the live inputs stand in for the latched copy.
  always_comb begin
    if (state == S_IDLE) begin
      cur_idx   = bus.data_addr[IW+1:2];
      cur_wdata = bus.data_in;
      cur_write = bus.mem_write;
      cur_err   = req_illegal;
    end else begin
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_write = write_q;
      cur_err   = err_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    latch_en   = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          if (req_illegal || (WAIT_CYCLES == 0)) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CW'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (cnt != CW'(1)) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c  = (state != S_IDLE);
    ready_c = (state == S_RESP);
    err_c   = (state == S_RESP) && err_q;
  end

  assign commit_we = enter_resp & cur_write & ~cur_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (latch_en) begin
        idx_q   <= bus.data_addr[IW+1:2];
        wdata_q <= bus.data_in;
        write_q <= bus.mem_write;
        err_q   <= req_illegal;
      end
      // Error responses clear data_out; legal writes leave it untouched.
      if (enter_resp) begin
        if (cur_err)         data_out_q <= '0;
        else if (!cur_write) data_out_q <= mem[cur_idx];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_we) mem[cur_idx] <= cur_wdata;
  end

  assign bus.data_out  = data_out_q;
  assign bus.mem_ready = ready_c;
  assign bus.mem_err   = err_c;
  assign bus.busy      = busy_c;
  assign dbg_state     = state;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the processor's data port (data_addr, data_in, mem_read, mem_write, data_out).
- Services one load or store at a time with a programmable number of wait states and a registered ready/error handshake.
- Gives the datapath a realistic, stallable memory target in place of a zero-latency array.
- Word-addressed internal storage; byte address supplied by the processor.

Parameters:
- DEPTH, 256, number of 32-bit words stored; legal byte addresses are 0 to 4*DEPTH-4.
- WAIT_CYCLES, 2, wait states between request acceptance and response; 0 is legal.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_addr  input  32  byte address of the access.
- data_in  input  32  store data.
- mem_read  input  1  load request.
- mem_write  input  1  store request.
- data_out  output  32  load data; valid while mem_ready=1 for a read.
- mem_ready  output  1  one-cycle response strobe.
- mem_err  output  1  error flag; valid only with mem_ready.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset: reset=0 asynchronously forces state=IDLE, counter=0, data_out=0, mem_ready=0, mem_err=0, busy=0. Storage contents are not reset.
- FSM states are IDLE, WAIT and RESP. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE:
  - At an edge where mem_read|mem_write=1, latch data_addr, data_in and the op (edge E0).
  - Legal request: go to WAIT with counter=WAIT_CYCLES, or go directly to RESP if WAIT_CYCLES=0.
  - Illegal request: go to RESP with the error flag set, skipping WAIT.
- Illegal request conditions:
  - mem_read and mem_write both 1.
  - data_addr[1:0] != 0.
  - data_addr[31:2] >= DEPTH.
- WAIT:
  - counter>1: decrement.
  - counter==1: go to RESP.
  - Inputs are ignored while in WAIT; the latched values are used.
  - Result: mem_ready rises after edge E_WAIT_CYCLES.
- Store commit: storage[addr[31:2]] is written with the latched data on the edge that enters RESP, and only for a legal write.
- Load data: on the edge entering RESP for a legal read, data_out is loaded with storage[addr[31:2]].
- RESP:
  - Lasts exactly one cycle: mem_ready=1, mem_err per the latched error flag, busy=1.
  - The next state is always IDLE.
- data_out on other responses:
  - Unchanged on a legal write response.
  - Cleared to 0 on an error response.
  - Holds its value otherwise.
- Handshake:
  - The requester holds its request until it samples mem_ready=1.
  - A request still asserted in the cycle after RESP is accepted in IDLE as a new access.
  - Requests or input changes while busy=1 are ignored.
- Throughput: a legal access occupies WAIT_CYCLES+2 cycles, counting IDLE acceptance through RESP.
- Reset mid-operation: a write aborted in WAIT is never committed. A write aborted on the RESP-entry edge is committed if the edge completed before reset fell.
- Counter width is max(1, clog2(WAIT_CYCLES+1)).

Test Plan:
- Timed store then load: reset release, WAIT_CYCLES=2, write 0xDEADBEEF to 0x10 → busy=1 for 3 cycles, mem_ready=1 exactly after the second edge post-acceptance, mem_err=0. Then read 0x10 → data_out=0xDEADBEEF with mem_ready.
- Misaligned read: read at 0x13 → mem_ready and mem_err=1 one cycle after acceptance, data_out=0.
- Out-of-range store: with DEPTH=256, write 0xFFFFFFFF to 0x400 → mem_err=1. A following read of 0x0 returns the value previously written there (0x5555AAAA).
- Dual request: mem_read=mem_write=1 at 0x20 → mem_err=1, and storage[8] is unchanged on readback.
- Reset during WAIT: write 0x00005555 to 0x20 and complete it. Start a write of 0x00001234 to 0x20 and pulse reset=0 during WAIT → all outputs 0 immediately. A later read of 0x20 returns 0x00005555.
- Held and changing requests:
  - WAIT_CYCLES=0, mem_read held high at 0x10 → two back-to-back responses, 2 cycles apart.
  - With WAIT_CYCLES=2, change data_addr during WAIT → the response uses the originally latched address.
